// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter.
//
// A WIDTH-bit word is accepted through a valid/ready handshake and sent
// out one bit per clock on shift_out. The last bit of one frame and the
// acceptance of the next word fall on the same cycle. This gives gapless
// back-to-back frames.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   load_valid  load_data holds a word to transmit
//   load_data   parallel word to serialize (WIDTH bits)
//   load_ready  a word can be accepted this cycle
//   shift_out   serial data line (IDLE_LEVEL outside frames)
//   shift_valid shift_out carries a frame bit this cycle
//   busy        a frame is in progress
//   done        high during the last bit of a frame
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             shift_out,
  output logic             shift_valid,
  output logic             busy,
  output logic             done
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sreg_r, sreg_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             last_s;
  logic             ready_s;
  logic             accept_s;

  // Move the register one place toward the output end and fill with zero.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) begin
      shift_step = {v[WIDTH-2:0], 1'b0};
    end else begin
      shift_step = {1'b0, v[WIDTH-1:1]};
    end
  endfunction

  // Handshake decode and next-state logic.
  always_comb begin
    last_s   = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);
    ready_s  = (state_r == ST_IDLE) || last_s;
    accept_s = load_valid && ready_s;
    state_s  = state_r;
    sreg_s   = sreg_r;
    cnt_s    = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_SHIFT;
          sreg_s  = load_data;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (accept_s) begin
          // A reload on the last-bit cycle starts the next frame with no gap.
          state_s = ST_SHIFT;
          sreg_s  = load_data;
          cnt_s   = CNT_ZERO;
        end else if (last_s) begin
          state_s = ST_IDLE;
          sreg_s  = shift_step(sreg_r);
          cnt_s   = CNT_ZERO;
        end else begin
          sreg_s  = shift_step(sreg_r);
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        sreg_s  = '0;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, shift register and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sreg_r  <= '0;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      sreg_r  <= sreg_s;
      cnt_r   <= cnt_s;
    end
  end

  // The output bit is taken straight from a register bit. load_data has
  // no path to shift_out.
  assign shift_out   = (state_r == ST_SHIFT) ?
                       (MSB_FIRST ? sreg_r[WIDTH-1] : sreg_r[0]) : IDLE_LEVEL;
  assign shift_valid = (state_r == ST_SHIFT);
  assign busy        = (state_r == ST_SHIFT);
  assign done        = last_s;
  assign load_ready  = ready_s;

endmodule
